rmt_ingress_arbiter: RTL and testbench

RMT_INGRESS_ARBITER -- requirements
Module: rmt_ingress_arbiter

---
 rtl/rmt_pkg.sv | 17 +
 rtl/rmt_ingress_arbiter_if.sv | 22 ++
 rtl/rmt_rr_select.sv | 31 +++
 rtl/rmt_ingress_arbiter.sv | 93 +++++++++
 tb/tb_rmt_ingress_arbiter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rmt_pkg.sv
// Shared definitions for the RMT ingress arbiter: FSM encoding, counter width
// and the round-robin index helper.
package rmt_pkg;

  localparam int CNT_WIDTH = 16;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } rmt_state_t;

  // Index reached by stepping 'off' positions past 'idx' on a ring of 'n' ports.
  function automatic int unsigned rr_next(int unsigned idx, int unsigned off, int unsigned n);
    return (idx + off) % n;
  endfunction

endpackage

// File: rtl/rmt_ingress_arbiter_if.sv
// AXI-Stream bundle carrying LANES packed streams side by side.
// Handshake: a beat moves on lane i exactly when tvalid[i] && tready[i] at a
// rising clk edge; the source holds tdata/tkeep/tuser/tlast stable while
// tvalid is high and tready is low.
interface rmt_ingress_arbiter_if #(
  parameter int LANES      = 1,
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 8,
  parameter int ID_WIDTH   = 2
);
  logic [LANES*DATA_WIDTH-1:0] tdata;
  logic [LANES*KEEP_WIDTH-1:0] tkeep;
  logic [LANES-1:0]            tvalid;
  logic [LANES-1:0]            tready;
  logic [LANES-1:0]            tlast;
  logic [LANES*USER_WIDTH-1:0] tuser;
  logic [ID_WIDTH-1:0]         tid;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, tid, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, tid, output tready);
endinterface

// File: rtl/rmt_rr_select.sv
// Purely combinational round-robin picker: first requesting index strictly
// after last_grant, wrapping around the ring.
module rmt_rr_select
  import rmt_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   request,
  input  logic [IDW-1:0] last_grant,
  output logic           valid,
  output logic [IDW-1:0] grant
);

  logic [IDW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    valid = 1'b0;
    grant = '0;
    idx   = '0;
    for (int off = N; off >= 1; off--) begin
      idx = IDW'(rr_next(32'(last_grant), 32'(off), 32'(N)));
      if (request[idx]) begin
        valid = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/rmt_ingress_arbiter.sv
// Frame-granular round-robin merge of S_COUNT AXI-Stream requesters into one
// stream for the classifier. A grant is held from the first beat to tlast,
// with one idle bubble cycle between frames.
module rmt_ingress_arbiter
  import rmt_pkg::*;
#(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 8,
  parameter int ID_WIDTH   = $clog2(S_COUNT)
) (
  input  logic                         clk,
  input  logic                         rst,
  rmt_ingress_arbiter_if.slave         s_axis,
  rmt_ingress_arbiter_if.master        m_axis,
  input  logic [S_COUNT-1:0]           port_enable,
  output logic [S_COUNT*CNT_WIDTH-1:0] frame_count,
  output logic                         busy,
  output rmt_state_t                   state_dbg
);

  rmt_state_t                          state, state_next;
  logic [ID_WIDTH-1:0]                 grant, last_grant, sel_grant;
  logic                                sel_valid;
  logic [S_COUNT-1:0]                  req;
  logic [S_COUNT-1:0][CNT_WIDTH-1:0]   cnt_q;
  logic                                beat, frame_done;

  assign req        = s_axis.tvalid & port_enable;
  assign beat       = (state == ST_LOCKED) && s_axis.tvalid[grant] && m_axis.tready[0];
  assign frame_done = beat && s_axis.tlast[grant];
  assign frame_count = cnt_q;

  rmt_rr_select #(
    .N   (S_COUNT),
    .IDW (ID_WIDTH)
  ) u_rr_select (
    .request    (req),
    .last_grant (last_grant),
    .valid      (sel_valid),
    .grant      (sel_grant)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next state: lock on any enabled request, release on the tlast beat.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (sel_valid)  state_next = ST_LOCKED;
      ST_LOCKED: if (frame_done) state_next = ST_IDLE;
      default:                   state_next = ST_IDLE;
    endcase
  end

  // Outputs: pass the granted lane straight through while locked, quiet in idle.
  always_comb begin
    m_axis.tdata  = s_axis.tdata[grant*DATA_WIDTH +: DATA_WIDTH];
    m_axis.tkeep  = s_axis.tkeep[grant*KEEP_WIDTH +: KEEP_WIDTH];
    m_axis.tuser  = s_axis.tuser[grant*USER_WIDTH +: USER_WIDTH];
    m_axis.tlast  = s_axis.tlast[grant];
    m_axis.tid    = grant;
    m_axis.tvalid = '0;
    s_axis.tready = '0;
    if (state == ST_LOCKED) begin
      m_axis.tvalid[0]     = s_axis.tvalid[grant];
      s_axis.tready[grant] = m_axis.tready[0];
    end
    busy      = (state == ST_LOCKED);
    state_dbg = state;
  end

  // Grant capture, round-robin pointer and per-port completed-frame counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= '0;
      last_grant <= ID_WIDTH'(S_COUNT - 1);
      cnt_q      <= '0;
    end else begin
      if (state == ST_IDLE && sel_valid) grant <= sel_grant;
      if (frame_done) begin
        last_grant   <= grant;
        cnt_q[grant] <= cnt_q[grant] + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_rmt_ingress_arbiter.sv
// Directed bench for rmt_ingress_arbiter with per-port source queues and an
// expected-beat scoreboard.
module tb_rmt_ingress_arbiter;
  import rmt_pkg::*;

  localparam int S  = 4;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int UW = 8;
  localparam int IW = 2;
  localparam int SW = 1 + UW + KW + DW;
  localparam int EW = IW + SW;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [S-1:0]           port_enable;
  logic [S*CNT_WIDTH-1:0] frame_count;
  logic                   busy;
  rmt_state_t             state_dbg;

  rmt_ingress_arbiter_if #(.LANES(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .ID_WIDTH(IW)) s_axis();
  rmt_ingress_arbiter_if #(.LANES(1), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .ID_WIDTH(IW)) m_axis();

  rmt_ingress_arbiter #(
    .S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .ID_WIDTH(IW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_axis      (s_axis),
    .m_axis      (m_axis),
    .port_enable (port_enable),
    .frame_count (frame_count),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // Scoreboard state
  logic [SW-1:0] src_q [S][$];
  logic [EW-1:0] exp_q [$];
  int            beat_cyc [$];
  int            exp_cnt [S];
  logic [S-1:0]  stall;
  logic          toggle_ready;
  int            checks   = 0;
  int            failures = 0;
  int            cycle    = 0;
  int            t0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SW-1:0] mk_beat(input int p, input int fid, input int b, input int n);
    logic          last;
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    last = (b == n - 1);
    d    = {8'(p), 8'(fid), 16'(b)};
    k    = last ? 4'b0011 : 4'b1111;
    u    = 8'(fid) ^ 8'(p);
    return {last, u, k, d};
  endfunction

  // Driver tasks
  task automatic add_src(input int p, input int fid, input int n);
    for (int b = 0; b < n; b++) src_q[p].push_back(mk_beat(p, fid, b, n));
  endtask

  task automatic add_exp(input int p, input int fid, input int n);
    for (int b = 0; b < n; b++) exp_q.push_back({IW'(p), mk_beat(p, fid, b, n)});
    exp_cnt[p]++;
  endtask

  task automatic update_drive();
    for (int p = 0; p < S; p++) begin
      if (src_q[p].size() > 0 && !stall[p]) begin
        s_axis.tvalid[p] = 1'b1;
        {s_axis.tlast[p], s_axis.tuser[p*UW +: UW], s_axis.tkeep[p*KW +: KW],
         s_axis.tdata[p*DW +: DW]} = src_q[p][0];
      end else begin
        s_axis.tvalid[p] = 1'b0;
        s_axis.tlast[p]  = 1'b0;
      end
    end
  endtask

  // One clock: sample/compare at negedge, advance sources #1 after posedge.
  task automatic tick();
    logic [S-1:0]  hs;
    logic [EW-1:0] e;
    @(negedge clk);
    hs = s_axis.tvalid & s_axis.tready;
    if (m_axis.tvalid[0] && m_axis.tready[0]) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("beat", 64'({m_axis.tid, m_axis.tlast[0], m_axis.tuser, m_axis.tkeep, m_axis.tdata}), 64'(e));
        beat_cyc.push_back(cycle);
      end
    end
    if (toggle_ready && m_axis.tvalid[0])
      check("s_ready_mirror", 64'(s_axis.tready), 64'({2'b00, m_axis.tready[0], 1'b0}));
    @(posedge clk);
    cycle++;
    #1;
    for (int p = 0; p < S; p++)
      if (hs[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
    if (toggle_ready) m_axis.tready[0] = ~m_axis.tready[0];
    update_drive();
  endtask

  task automatic drain(input int budget, input int tail, input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (tail) tick();
  endtask

  task automatic check_counts(input string tag);
    for (int p = 0; p < S; p++)
      check($sformatf("%s_cnt%0d", tag, p), 64'(frame_count[p*CNT_WIDTH +: CNT_WIDTH]),
            64'(exp_cnt[p] % 65536));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},   64'(busy),          64'd0);
    check({tag, "_mvalid"}, 64'(m_axis.tvalid), 64'd0);
    check({tag, "_sready"}, 64'(s_axis.tready), 64'd0);
    check({tag, "_fcnt"},   64'(frame_count),   64'd0);
    check({tag, "_tid"},    64'(m_axis.tid),    64'd0);
    check({tag, "_state"},  64'(state_dbg),     64'(ST_IDLE));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int p = 0; p < S; p++) src_q[p].delete();
    exp_q.delete();
    stall = '0;
    m_axis.tready = 1'b1;
    update_drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int p = 0; p < S; p++) exp_cnt[p] = 0;
  endtask

  // Directed sequence
  initial begin
    rst           = 1'b1;
    port_enable   = '1;
    stall         = '0;
    toggle_ready  = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tkeep  = '0;
    s_axis.tuser  = '0;
    s_axis.tlast  = '0;
    s_axis.tvalid = '0;
    s_axis.tid    = '0;
    m_axis.tready = 1'b1;
    do_reset();
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk);
    #1;

    // Ports 0 and 2 collide: 0 first, one bubble, then 2.
    add_src(0, 1, 3); add_src(2, 1, 3);
    add_exp(0, 1, 3); add_exp(2, 1, 3);
    beat_cyc.delete();
    t0 = cycle;
    update_drive();
    drain(40, 2, "t27");
    check("t27_nbeats", 64'(beat_cyc.size()), 64'd6);
    if (beat_cyc.size() == 6) begin
      check("t27_first_latency", 64'(beat_cyc[0] - t0), 64'd1);
      check("t27_back_to_back",  64'(beat_cyc[1] - beat_cyc[0]), 64'd1);
      check("t27_bubble",        64'(beat_cyc[3] - beat_cyc[2]), 64'd2);
    end
    check_counts("t27");

    // All four ports offer single-beat frames: strict rotation 0,1,2,3,0,1,2,3.
    do_reset();
    for (int p = 0; p < S; p++) begin
      add_src(p, 10, 1);
      add_src(p, 11, 1);
    end
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < S; p++) add_exp(p, 10 + f, 1);
    update_drive();
    drain(60, 2, "t28");
    check_counts("t28");

    // Backpressure toggling on a 4-beat frame from port 1.
    add_src(1, 20, 4);
    add_exp(1, 20, 4);
    toggle_ready = 1'b1;
    update_drive();
    drain(40, 0, "t29");
    toggle_ready  = 1'b0;
    m_axis.tready = 1'b1;
    update_drive();
    check_counts("t29");

    // Source drops tvalid mid-frame: grant held, output idle-valid.
    add_src(2, 30, 3);
    add_exp(2, 30, 3);
    update_drive();
    tick(); tick();
    stall[2] = 1'b1;
    update_drive();
    repeat (2) begin
      tick();
      check("t20_busy",   64'(busy),          64'd1);
      check("t20_mvalid", 64'(m_axis.tvalid), 64'd0);
      check("t20_tid",    64'(m_axis.tid),    64'd2);
    end
    stall[2] = 1'b0;
    update_drive();
    drain(40, 1, "t20");
    check_counts("t20");

    // Port 3 disabled mid-frame: frame finishes, then port 3 is skipped.
    add_src(3, 40, 4);
    add_exp(3, 40, 4);
    update_drive();
    tick(); tick();
    port_enable = 4'b0111;
    add_src(3, 41, 2);
    for (int p = 0; p < 3; p++) add_src(p, 42, 2);
    for (int p = 0; p < 3; p++) add_exp(p, 42, 2);
    update_drive();
    drain(80, 10, "t30");
    check_counts("t30");
    check("t30_p3_untouched", 64'(src_q[3].size()), 64'd2);
    src_q[3].delete();
    port_enable = '1;
    update_drive();

    // Reset on the 2nd beat of a 5-beat frame from port 2.
    add_src(2, 50, 5);
    exp_q.push_back({IW'(2), mk_beat(2, 50, 0, 5)});
    update_drive();
    tick(); tick();
    check("t31_first_beat_seen", 64'(exp_q.size()), 64'd0);
    rst = 1'b1;
    m_axis.tready = 1'b0;
    tick();
    check_quiet("t31_after_rst");
    for (int p = 0; p < S; p++) begin
      src_q[p].delete();
      exp_cnt[p] = 0;
    end
    exp_q.delete();
    m_axis.tready = 1'b1;
    update_drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    add_src(1, 60, 1); add_src(2, 60, 1);
    add_exp(1, 60, 1); add_exp(2, 60, 1);
    update_drive();
    drain(40, 1, "t31");
    check_counts("t31");

    // Counter wrap on port 0.
    do_reset();
    force dut.cnt_q = {48'h0, 16'hFFFF};
    #1;
    release dut.cnt_q;
    check("t32_preload", 64'(frame_count), 64'h0000_0000_0000_FFFF);
    exp_cnt[0] = 65535;
    add_src(0, 70, 2);
    add_exp(0, 70, 2);
    update_drive();
    drain(40, 1, "t32");
    check_counts("t32");

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
